// File: rtl/decoder38_reg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder38_reg
//  Description : 3-to-8 one-hot decoder with a 2-entry in-order output FIFO,
//                valid/ready handshakes on both sides, a wrapping count of
//                delivered words, and an optional odd-parity check on input.
//                Optional feature macro: DECODER38_PARITY_EN
//                  defined   -> codes failing odd parity are consumed but not
//                               queued, and par_err becomes sticky-high.
//                  undefined -> in_par is ignored, par_err is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder38_reg #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_code,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_d,
    output logic [CNT_W-1:0] dec_count,
    output logic             par_err
);

    // FIFO occupancy encoding
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       head_q,  head_d;   // code of the word currently presented
    logic [2:0]       tail_q,  tail_d;   // code of the second word when in TWO
    logic [CNT_W-1:0] count_q, count_d;

    logic in_fire;   // input handshake completes this cycle
    logic code_ok;   // accepted code is eligible to be queued
    logic push;
    logic pop;

    assign in_fire = in_valid && in_ready;
    assign push    = in_fire && code_ok;
    assign pop     = out_valid && out_ready;

`ifdef DECODER38_PARITY_EN
    logic par_err_q, par_err_d;

    // Odd parity over {in_par, in_code} marks a good code
    assign code_ok = ^{in_par, in_code};

    // Sticky error flag: any handshaken code with bad parity sets it
    always_comb begin
        par_err_d = par_err_q;
        if (in_fire && !code_ok) begin
            par_err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    logic unused_in_par;

    // Parity bit has no effect in this build
    assign unused_in_par = in_par;
    assign code_ok       = 1'b1;
    assign par_err       = 1'b0;
`endif

    // State register: occupancy of the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: push raises occupancy, pop lowers it, both cancel
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_d = ST_TWO;
                end else if (pop && !push) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can happen
                if (pop) begin
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Output logic: handshake flags depend on registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_d     = 8'h00;
        case (state_q)
            ST_EMPTY: begin
                in_ready = 1'b1;
            end
            ST_ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                out_d     = 8'd1 << head_q;
            end
            ST_TWO: begin
                out_valid = 1'b1;
                out_d     = 8'd1 << head_q;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Storage update: new codes land in head when it is free or being
    // vacated, otherwise behind it; a pop from TWO promotes the tail
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d = in_code;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = in_code;
                end else if (push) begin
                    tail_d = in_code;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                end
            end
            default: begin
                head_d = head_q;
            end
        endcase
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W
    always_comb begin
        count_d = count_q;
        if (pop) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Data and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= 3'd0;
            tail_q  <= 3'd0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dec_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder38_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder38_reg
//  Description : Scoreboard bench for decoder38_reg (CNT_W=4 so the counter
//                wrap is reachable quickly).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder38_reg;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_code;
    logic          in_par;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_d;
    logic [CW-1:0] dec_count;
    logic          par_err;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [2:0]    exp_q[$];
    logic [CW-1:0] cnt_model  = '0;
    logic          perr_model = 1'b0;
    logic [7:0]    exp_d;
    logic          mdl_ready;
    logic          mdl_valid;

    decoder38_reg #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_par    (in_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .dec_count (dec_count),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare DUT against the model each cycle, then advance the model to
    // what the coming rising edge will do
    always @(negedge clk) begin
        if (rst_n) begin
            mdl_ready = (exp_q.size() < 2);
            mdl_valid = (exp_q.size() > 0);
            exp_d     = mdl_valid ? (8'd1 << exp_q[0]) : 8'h00;
            check("in_ready",  {31'd0, in_ready},  {31'd0, mdl_ready});
            check("out_valid", {31'd0, out_valid}, {31'd0, mdl_valid});
            check("out_d",     {24'd0, out_d},     {24'd0, exp_d});
            check("dec_count", {{(32-CW){1'b0}}, dec_count}, {{(32-CW){1'b0}}, cnt_model});
            check("par_err",   {31'd0, par_err},   {31'd0, perr_model});
            if (mdl_valid && out_ready) begin
                void'(exp_q.pop_front());
                cnt_model = cnt_model + 1'b1;
            end
            if (in_valid && mdl_ready) begin
`ifdef DECODER38_PARITY_EN
                if (^{in_par, in_code}) begin
                    exp_q.push_back(in_code);
                end else begin
                    perr_model = 1'b1;
                end
`else
                exp_q.push_back(in_code);
`endif
            end
        end
    end

    // Present a code (good or bad parity) until accepted; returns 1 time unit
    // after the accepting edge with in_valid still high
    task automatic send(input logic [2:0] c, input bit good);
        int k;
        in_valid = 1'b1;
        in_code  = c;
        in_par   = good ? ~(^c) : (^c);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 20);
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        in_par    = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_d",     {24'd0, out_d},     32'd0);
        check("rst_dec_count", {{(32-CW){1'b0}}, dec_count}, 32'd0);
        check("rst_par_err",   {31'd0, par_err},   32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Codes 0..7 streamed with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(i[2:0], 1'b1);
            check("seq_latency", {24'd0, out_d}, 32'd1 << i);
        end
        idle_cycles(3);
        check("seq_count", {{(32-CW){1'b0}}, dec_count}, 32'd8);

        // Back-pressure: 3 and 5 fill the FIFO, 6 must wait
        out_ready = 1'b0;
        send(3'd3, 1'b1);
        send(3'd5, 1'b1);
        in_valid = 1'b1;
        in_code  = 3'd6;
        in_par   = ~(^3'd6);
        repeat (3) @(posedge clk);
        #1;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_hold_d",   {24'd0, out_d},    32'h08);
        out_ready = 1'b1;
        send(3'd6, 1'b1);
        idle_cycles(4);

        // ONE with simultaneous push and pop: no bubble
        out_ready = 1'b0;
        send(3'd1, 1'b1);
        idle_cycles(1);
        out_ready = 1'b1;
        send(3'd7, 1'b1);
        check("pp_out_d",     {24'd0, out_d},     32'h80);
        check("pp_out_valid", {31'd0, out_valid}, 32'd1);
        check("pp_in_ready",  {31'd0, in_ready},  32'd1);
        idle_cycles(3);

        // Reset while holding two words
        out_ready = 1'b0;
        send(3'd3, 1'b1);
        send(3'd5, 1'b1);
        idle_cycles(1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_d",     {24'd0, out_d},     32'd0);
        check("mid_rst_dec_count", {{(32-CW){1'b0}}, dec_count}, 32'd0);
        exp_q.delete();
        cnt_model  = '0;
        perr_model = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'd4, 1'b1);
        check("post_rst_d", {24'd0, out_d}, 32'h10);
        idle_cycles(3);

        // Counter wrap from a fresh count of 1 -> deliver 16 more words
        for (int i = 0; i < 16; i++) begin
            send(3'(i), 1'b1);
        end
        idle_cycles(3);
        check("wrap_count", {{(32-CW){1'b0}}, dec_count}, 32'd1);

        // Parity handling
        send(3'd2, 1'b0);
        idle_cycles(3);
`ifdef DECODER38_PARITY_EN
        check("bad_par_err", {31'd0, par_err}, 32'd1);
`else
        check("bad_par_err", {31'd0, par_err}, 32'd0);
`endif
        send(3'd2, 1'b1);
        check("good_par_d", {24'd0, out_d}, 32'h04);
        idle_cycles(3);
`ifdef DECODER38_PARITY_EN
        check("par_err_sticky", {31'd0, par_err}, 32'd1);
`else
        check("par_err_sticky", {31'd0, par_err}, 32'd0);
`endif
        check("final_empty", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
